// File: rtl/uart_top_afc.sv
// uart_top_afc: UART top with TX/RX FIFOs, baud generator, TX/RX cores,
// RTS/CTS auto flow control, RX error tags, sticky lsr, timeout and IRQ.
// Ports: clk/rst, i_rxd/o_txd, i_cts_n/o_rts_n, i_wr_en/i_wr_data,
//   i_rd_en/o_rd_data/o_rd_err/o_rx_valid, o_tx_level/o_rx_level,
//   line control, baud config, i_afc_en, i_rx_trig, i_ier, i_lsr_rd,
//   o_lsr, o_irq/o_irq_id.

module uart_afc_fifo #(
   parameter int W  = 8,
   parameter int D  = 16,
   parameter int LW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [W-1:0]  i_d,
   output logic [W-1:0]  o_q,
   output logic [LW-1:0] o_level
);
   localparam int AW = $clog2(D);
   logic [W-1:0]  r_mem [D];
   logic [AW-1:0] r_wp, r_rp;
   logic [LW-1:0] r_lvl;
   logic          w_push, w_pop;

   // Full is judged on the current level, so a same-cycle pop never
   // makes room for a push.
   assign w_push = i_push && (r_lvl != LW'(D));
   assign w_pop  = i_pop && (r_lvl != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_lvl <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         if (w_push && !w_pop)      r_lvl <= r_lvl + 1'b1;
         else if (w_pop && !w_push) r_lvl <= r_lvl - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_d;
   end

   assign o_q     = r_mem[r_rp];
   assign o_level = r_lvl;
endmodule

module uart_top_afc #(
   parameter int DL_WIDTH   = 16,
   parameter int PSD_WIDTH  = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int TOUT_BITS  = 40,
   localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rxd,
   output logic                 o_txd,
   input  logic                 i_cts_n,
   output logic                 o_rts_n,
   input  logic                 i_wr_en,
   input  logic [7:0]           i_wr_data,
   input  logic                 i_rd_en,
   output logic [7:0]           o_rd_data,
   output logic [2:0]           o_rd_err,
   output logic                 o_rx_valid,
   output logic [LW-1:0]        o_tx_level,
   output logic [LW-1:0]        o_rx_level,
   input  logic [1:0]           i_stop_bits,
   input  logic                 i_parity_en,
   input  logic                 i_parity_even,
   input  logic [3:0]           i_data_bits,
   input  logic [DL_WIDTH-1:0]  i_divisor_latch,
   input  logic [PSD_WIDTH-1:0] i_psd,
   input  logic                 i_new_baud,
   input  logic                 i_afc_en,
   input  logic [1:0]           i_rx_trig,
   input  logic [3:0]           i_ier,
   input  logic                 i_lsr_rd,
   output logic [2:0]           o_lsr,
   output logic                 o_irq,
   output logic [2:0]           o_irq_id
);
   localparam int TW = $clog2(TOUT_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT
   } state_t;

   // baud generator: r_t16 is the 16x oversample tick, r_btick one per bit
   logic [DL_WIDTH-1:0]  r_dl, r_dcnt;
   logic [PSD_WIDTH-1:0] r_psd, r_pcnt;
   logic [3:0]           r_t16cnt;
   logic                 r_t16, r_btick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dl     <= DL_WIDTH'(1);
         r_psd    <= '0;
         r_pcnt   <= '0;
         r_dcnt   <= '0;
         r_t16cnt <= '0;
         r_t16    <= 1'b0;
         r_btick  <= 1'b0;
      end else begin
         r_t16   <= 1'b0;
         r_btick <= 1'b0;
         if (i_new_baud) begin
            r_dl   <= (i_divisor_latch == '0) ? DL_WIDTH'(1) : i_divisor_latch;
            r_psd  <= i_psd;
            r_pcnt <= '0;
            r_dcnt <= '0;
         end else if (r_pcnt != r_psd) begin
            r_pcnt <= r_pcnt + 1'b1;
         end else begin
            r_pcnt <= '0;
            if (r_dcnt == r_dl - 1'b1) begin
               r_dcnt   <= '0;
               r_t16    <= 1'b1;
               r_t16cnt <= r_t16cnt + 1'b1;
               if (r_t16cnt == 4'hF) r_btick <= 1'b1;
            end else begin
               r_dcnt <= r_dcnt + 1'b1;
            end
         end
      end
   end

   // synchronisers; both idle high
   logic r_cts1, r_cts_s, r_rx1, r_rx_s;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cts1  <= 1'b1;
         r_cts_s <= 1'b1;
         r_rx1   <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_cts1  <= i_cts_n;
         r_cts_s <= r_cts1;
         r_rx1   <= i_rxd;
         r_rx_s  <= r_rx1;
      end
   end

   logic [3:0] w_nbits;
   logic [2:0] w_last;
   logic [7:0] w_mask;
   assign w_nbits = (i_data_bits > 4'd8) ? 4'd8 :
                    (i_data_bits < 4'd5) ? 4'd5 : i_data_bits;
   assign w_last  = 3'(w_nbits - 4'd1);
   assign w_mask  = 8'hFF >> (4'd8 - w_nbits);

   // TX path
   logic [7:0]    w_tx_q;
   logic [LW-1:0] w_tx_lvl;
   logic          w_launch, w_tend;
   state_t        r_txst;
   logic [7:0]    r_tsh;
   logic [4:0]    r_tcnt, w_tlim;
   logic [2:0]    r_tbit;
   logic          r_tpar, r_txd;

   assign w_launch = (r_txst == S_IDLE) && (w_tx_lvl != '0) &&
                     (!i_afc_en || !r_cts_s);

   uart_afc_fifo #(.W(8), .D(FIFO_DEPTH), .LW(LW)) u_txf (
      .clk(clk), .rst(rst), .i_push(i_wr_en), .i_pop(w_launch),
      .i_d(i_wr_data), .o_q(w_tx_q), .o_level(w_tx_lvl)
   );

   // stop length in 16x ticks: 1, 1.5 or 2 bits
   assign w_tlim = (r_txst != S_STOP)    ? 5'd15 :
                   (i_stop_bits == 2'd0) ? 5'd15 :
                   (i_stop_bits == 2'd1) ? 5'd23 : 5'd31;
   assign w_tend = r_t16 && (r_tcnt == w_tlim);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_txst <= S_IDLE;
         r_txd  <= 1'b1;
         r_tsh  <= '0;
         r_tpar <= 1'b0;
         r_tcnt <= '0;
         r_tbit <= '0;
      end else begin
         if (r_txst != S_IDLE && r_t16)
            r_tcnt <= w_tend ? 5'd0 : r_tcnt + 1'b1;
         case (r_txst)
            S_IDLE: if (w_launch) begin
               r_txst <= S_START;
               r_txd  <= 1'b0;
               r_tsh  <= w_tx_q & w_mask;
               r_tpar <= (^(w_tx_q & w_mask)) ^ ~i_parity_even;
               r_tcnt <= '0;
               r_tbit <= '0;
            end
            S_START: if (w_tend) begin
               r_txst <= S_DATA;
               r_txd  <= r_tsh[0];
            end
            S_DATA: if (w_tend) begin
               if (r_tbit == w_last) begin
                  r_txst <= i_parity_en ? S_PAR : S_STOP;
                  r_txd  <= i_parity_en ? r_tpar : 1'b1;
               end else begin
                  r_tbit <= r_tbit + 1'b1;
                  r_tsh  <= r_tsh >> 1;
                  r_txd  <= r_tsh[1];
               end
            end
            S_PAR: if (w_tend) begin
               r_txst <= S_STOP;
               r_txd  <= 1'b1;
            end
            S_STOP: if (w_tend) r_txst <= S_IDLE;
            default: begin
               r_txst <= S_IDLE;
               r_txd  <= 1'b1;
            end
         endcase
      end
   end

   // RX path: start validated at mid start bit, bits sampled mid-bit
   state_t     r_rxst;
   logic [3:0] r_rcnt;
   logic [2:0] r_rbit;
   logic [7:0] r_rsh, w_rdata;
   logic       r_rpar, r_rfe, r_store, w_rmid, w_pe, w_brk;

   assign w_rmid = r_t16 && (r_rcnt == 4'd15);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rxst  <= S_IDLE;
         r_rcnt  <= '0;
         r_rbit  <= '0;
         r_rsh   <= '0;
         r_rpar  <= 1'b0;
         r_rfe   <= 1'b0;
         r_store <= 1'b0;
      end else begin
         r_store <= 1'b0;
         if (r_t16 && r_rxst != S_IDLE && r_rxst != S_WAIT)
            r_rcnt <= r_rcnt + 1'b1;
         case (r_rxst)
            S_IDLE: if (r_t16 && !r_rx_s) begin
               r_rxst <= S_START;
               r_rcnt <= '0;
            end
            S_START: if (r_t16 && r_rcnt == 4'd7) begin
               r_rcnt <= '0;
               r_rbit <= '0;
               r_rxst <= r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_rmid) begin
               r_rsh  <= {r_rx_s, r_rsh[7:1]};
               r_rbit <= r_rbit + 1'b1;
               if (r_rbit == w_last)
                  r_rxst <= i_parity_en ? S_PAR : S_STOP;
            end
            S_PAR: if (w_rmid) begin
               r_rpar <= r_rx_s;
               r_rxst <= S_STOP;
            end
            S_STOP: if (w_rmid) begin
               r_rfe   <= !r_rx_s;
               r_store <= 1'b1;
               r_rxst  <= S_WAIT;
            end
            // hold off a new start until the line returns high (break)
            S_WAIT: if (r_rx_s) r_rxst <= S_IDLE;
            default: r_rxst <= S_IDLE;
         endcase
      end
   end

   assign w_rdata = r_rsh >> (4'd8 - w_nbits);
   assign w_pe    = i_parity_en & ((^w_rdata) ^ r_rpar ^ ~i_parity_even);
   assign w_brk   = r_rfe && (w_rdata == 8'h00);

   logic [10:0]   w_rx_q;
   logic [LW-1:0] w_rx_lvl, w_trig;
   logic          w_rx_full;

   assign w_rx_full = (w_rx_lvl == LW'(FIFO_DEPTH));

   uart_afc_fifo #(.W(11), .D(FIFO_DEPTH), .LW(LW)) u_rxf (
      .clk(clk), .rst(rst), .i_push(r_store), .i_pop(i_rd_en),
      .i_d({w_brk, r_rfe, w_pe, w_rdata}), .o_q(w_rx_q), .o_level(w_rx_lvl)
   );

   assign w_trig = (i_rx_trig == 2'd0) ? LW'(1) :
                   (i_rx_trig == 2'd1) ? LW'(FIFO_DEPTH / 4) :
                   (i_rx_trig == 2'd2) ? LW'(FIFO_DEPTH / 2) :
                                         LW'(FIFO_DEPTH - 2);

   // status, flow control, timeout and interrupt
   logic [7:0]    r_rd_data;
   logic [2:0]    r_rd_err, r_lsr, r_irq_id, w_id;
   logic          r_rx_valid, r_rts_n, r_tout, r_irq;
   logic [TW-1:0] r_tocnt;

   always_comb begin
      w_id = 3'b000;
      if (i_ier[3] && r_lsr != 3'b000)   w_id = 3'b011;
      else if (i_ier[2] && w_rx_lvl >= w_trig) w_id = 3'b010;
      else if (i_ier[1] && r_tout)       w_id = 3'b110;
      else if (i_ier[0] && w_tx_lvl == '0) w_id = 3'b001;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_err   <= '0;
         r_rx_valid <= 1'b0;
         r_lsr      <= '0;
         r_rts_n    <= 1'b1;
         r_tocnt    <= '0;
         r_tout     <= 1'b0;
         r_irq      <= 1'b0;
         r_irq_id   <= '0;
      end else begin
         r_rx_valid <= i_rd_en && (w_rx_lvl != '0);
         if (i_rd_en && w_rx_lvl != '0) begin
            r_rd_data <= w_rx_q[7:0];
            r_rd_err  <= w_rx_q[10:8];
         end
         // new errors are ORed after the clear so they survive lsr_rd
         r_lsr <= (i_lsr_rd ? 3'b000 : r_lsr) |
                  (r_store ? {w_rx_full, r_rfe, w_pe} : 3'b000);
         if (!i_afc_en)                r_rts_n <= 1'b0;
         else if (w_rx_lvl >= w_trig)  r_rts_n <= 1'b1;
         else if (w_rx_lvl == '0)      r_rts_n <= 1'b0;
         if (r_store || i_rd_en || w_rx_lvl == '0)
            r_tocnt <= '0;
         else if (r_btick && r_tocnt != TW'(TOUT_BITS))
            r_tocnt <= r_tocnt + 1'b1;
         if (i_rd_en)                          r_tout <= 1'b0;
         else if (r_tocnt == TW'(TOUT_BITS))   r_tout <= 1'b1;
         r_irq_id <= w_id;
         r_irq    <= (w_id != 3'b000);
      end
   end

   assign o_txd      = r_txd;
   assign o_rts_n    = r_rts_n;
   assign o_rd_data  = r_rd_data;
   assign o_rd_err   = r_rd_err;
   assign o_rx_valid = r_rx_valid;
   assign o_tx_level = w_tx_lvl;
   assign o_rx_level = w_rx_lvl;
   assign o_lsr      = r_lsr;
   assign o_irq      = r_irq;
   assign o_irq_id   = r_irq_id;
endmodule

// File: tb/tb_uart_top_afc.sv
// tb_uart_top_afc: scoreboard bench for uart_top_afc; TX bytes are decoded
// off txd, RX bytes are driven on rxd and popped through rd_en.

module tb_uart_top_afc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rxd, txd, cts_n, rts_n;
   logic        wr_en, rd_en, rx_valid;
   logic [7:0]  wr_data, rd_data;
   logic [2:0]  rd_err, lsr, irq_id;
   logic [4:0]  tx_level, rx_level;
   logic [1:0]  stop_bits, rx_trig;
   logic        par_en, par_even, new_baud, afc_en, lsr_rd, irq;
   logic [3:0]  data_bits, ier;
   logic [15:0] dl;
   logic [3:0]  psd;

   always #5 clk = ~clk;

   uart_top_afc dut (
      .clk(clk), .rst(rst), .i_rxd(rxd), .o_txd(txd),
      .i_cts_n(cts_n), .o_rts_n(rts_n),
      .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
      .o_rd_data(rd_data), .o_rd_err(rd_err), .o_rx_valid(rx_valid),
      .o_tx_level(tx_level), .o_rx_level(rx_level),
      .i_stop_bits(stop_bits), .i_parity_en(par_en),
      .i_parity_even(par_even), .i_data_bits(data_bits),
      .i_divisor_latch(dl), .i_psd(psd), .i_new_baud(new_baud),
      .i_afc_en(afc_en), .i_rx_trig(rx_trig), .i_ier(ier),
      .i_lsr_rd(lsr_rd), .o_lsr(lsr), .o_irq(irq), .o_irq_id(irq_id)
   );

   int n_chk = 0;
   int n_err = 0;
   logic [7:0]  tx_q [$];
   logic [10:0] rx_q [$];
   bit mon_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bitp(input logic v);
      rxd = v;
      tick(16);
   endtask

   task automatic push(input logic [7:0] d);
      wr_data = d;
      wr_en   = 1'b1;
      if (mon_en) tx_q.push_back(d);
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic rx_frame(input logic [7:0] d, input bit bpar,
                           input bit bstop, input bit drop);
      logic p;
      p = (^d) ^ ~par_even ^ bpar;
      if (!drop)
         rx_q.push_back({bstop && d == 8'h00, bstop, bpar && par_en, d});
      bitp(1'b0);
      for (int i = 0; i < 8; i++) bitp(d[i]);
      if (par_en) bitp(p);
      bitp(!bstop);
      rxd = 1'b1;
      tick(4);
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      chk("rx_valid", rx_valid, 1);
      chk("rx_q_nonempty", rx_q.size() > 0, 1);
      if (rx_q.size() > 0)
         chk("rx_word", {rd_err, rd_data}, rx_q.pop_front());
   endtask

   // TX decoder: 8N1, 16 clocks per bit, sampled mid-bit
   initial forever begin
      @(negedge txd);
      if (mon_en) begin : dec
         logic [7:0] b;
         repeat (8) @(posedge clk);
         #1 chk("tx_start", txd, 0);
         for (int i = 0; i < 8; i++) begin
            repeat (16) @(posedge clk);
            #1 b[i] = txd;
         end
         repeat (16) @(posedge clk);
         #1 chk("tx_stop", txd, 1);
         chk("tx_q_nonempty", tx_q.size() > 0, 1);
         if (tx_q.size() > 0) chk("tx_byte", b, tx_q.pop_front());
      end
   end

   initial begin
      bit found;
      rxd = 1; cts_n = 0; wr_en = 0; wr_data = 0; rd_en = 0;
      stop_bits = 0; par_en = 0; par_even = 1; data_bits = 8;
      dl = 1; psd = 0; new_baud = 0; afc_en = 0; rx_trig = 0;
      ier = 0; lsr_rd = 0;
      tick(3);
      chk("rst_txd", txd, 1);
      chk("rst_rts", rts_n, 1);
      chk("rst_irq", irq, 0);
      chk("rst_irq_id", irq_id, 0);
      chk("rst_lsr", lsr, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_tx_level", tx_level, 0);
      chk("rst_rx_level", rx_level, 0);
      rst = 0;
      tick(2);
      chk("rts_no_afc", rts_n, 0);
      new_baud = 1;
      tick(1);
      new_baud = 0;

      // plain TX of 0xA5 with tx-empty interrupt
      ier = 4'b0001;
      tick(3);
      chk("irq_id_txe", irq_id, 3'b001);
      chk("irq_txe", irq, 1);
      mon_en = 1;
      push(8'hA5);
      chk("tx_lvl_1", tx_level, 1);
      tick(1);
      chk("tx_lvl_0", tx_level, 0);
      tick(170);
      chk("tx_drain", tx_q.size(), 0);
      chk("irq_id_txe2", irq_id, 3'b001);

      // CTS deasserted mid-frame holds the next launch
      ier = 0;
      afc_en = 1;
      push(8'h11); push(8'h22); push(8'h33);
      tick(60);
      cts_n = 1;
      tick(150);
      chk("cts_hold_lvl", tx_level, 2);
      chk("cts_hold_txd", txd, 1);
      tick(200);
      chk("cts_hold_lvl2", tx_level, 2);
      cts_n = 0;
      tick(1);
      chk("cts_sync1", txd, 1);
      tick(1);
      chk("cts_sync2", txd, 1);
      tick(1);
      chk("cts_launch", txd, 0);
      tick(340);
      chk("tx_flow_drain", tx_q.size(), 0);
      chk("tx_flow_lvl", tx_level, 0);

      // RTS against trigger DEPTH/2
      rx_trig = 2'b10;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("rts_below", rts_n, 0);
         rx_frame(8'(8'h31 + i * 8'h13), 0, 0, 0);
      end
      chk("rts_trig", rts_n, 1);
      chk("rx_lvl_8", rx_level, 8);
      for (int i = 0; i < 8; i++) begin
         pop_one();
         if (i == 6) chk("rts_hold", rts_n, 1);
      end
      tick(1);
      chk("rts_release", rts_n, 0);
      rd_en = 1;
      tick(1);
      rd_en = 0;
      chk("rd_empty_valid", rx_valid, 0);

      // overflow: 17th byte dropped, sticky overrun, line-status IRQ
      ier = 4'b1000;
      for (int i = 0; i < 16; i++)
         rx_frame(8'(i * 8'h0B + 8'h02), 0, 0, 0);
      chk("rx_lvl_full", rx_level, 16);
      rx_frame(8'h3C, 0, 0, 1);
      chk("rx_lvl_drop", rx_level, 16);
      chk("lsr_ovr", lsr, 3'b100);
      tick(2);
      chk("irq_id_ls", irq_id, 3'b011);
      lsr_rd = 1;
      tick(1);
      lsr_rd = 0;
      chk("lsr_clr", lsr, 0);
      for (int i = 0; i < 16; i++) pop_one();

      // bad parity and break tags
      par_en = 1;
      rx_frame(8'h55, 1, 0, 0);
      chk("lsr_par", lsr, 3'b001);
      pop_one();
      lsr_rd = 1; tick(1); lsr_rd = 0;
      rx_frame(8'h00, 0, 1, 0);
      chk("lsr_fe", lsr, 3'b010);
      pop_one();
      lsr_rd = 1; tick(1); lsr_rd = 0;
      chk("lsr_clr2", lsr, 0);

      // character timeout
      ier = 4'b1110;
      rx_frame(8'h7E, 0, 0, 0);
      tick(570);
      chk("tout_early", irq_id, 3'b000);
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         tick(1);
         if (irq_id == 3'b110) found = 1;
      end
      chk("tout_irq", irq_id, 3'b110);
      pop_one();
      tick(3);
      chk("tout_clr", irq_id, 3'b000);

      // reset in the middle of a TX frame
      mon_en = 0;
      push(8'h5A);
      push(8'h77);
      tick(5);
      chk("pre_rst_txd", txd, 0);
      #2 rst = 1;
      #1;
      chk("mid_rst_txd", txd, 1);
      chk("mid_rst_lvl", tx_level, 0);
      chk("mid_rst_rts", rts_n, 1);
      tick(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
